// File: rtl/nn_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// nn_ctrl_pkg
// Shared constants and types for the two-layer forward-pass sequencer.
//   - Lane and node counts of the shared neuron array.
//   - Phase-select encodings driven to the array.
//   - Controller state enumeration.
// ---------------------------------------------------------------------------
package nn_ctrl_pkg;

    localparam int NN_LANES   = 10;
    localparam int NN_H_NODES = 20;
    localparam int NN_O_NODES = 10;
    localparam int NN_TIMEOUT = 1024;
    localparam int NN_IDX_W   = 4;

    localparam logic [1:0] CTRL_H_UPPER = 2'b00;
    localparam logic [1:0] CTRL_H_LOWER = 2'b01;
    localparam logic [1:0] CTRL_OUT     = 2'b10;
    localparam logic [1:0] CTRL_IDLE    = 2'b11;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_H0_GO   = 4'd1,
        S_H0_WAIT = 4'd2,
        S_H1_GO   = 4'd3,
        S_H1_WAIT = 4'd4,
        S_O_GO    = 4'd5,
        S_O_WAIT  = 4'd6,
        S_ARGMAX  = 4'd7,
        S_DONE    = 4'd8,
        S_ERROR   = 4'd9
    } nn_state_e;

endpackage

// File: rtl/argmax_seq.sv
// ---------------------------------------------------------------------------
// argmax_seq
// Serial signed argmax over N bytes, one byte per cycle.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   go_i       : one-cycle pulse; slot 0 is taken as the initial maximum
//   values_i   : N signed bytes, slot i at [i*8 +: 8]
//   idx_o      : index of the maximum, valid while valid_o is high
//   valid_o    : one-cycle pulse in the cycle that examines the last slot
// A pass spans exactly N cycles counting the go cycle. The final compare is
// folded into idx_o combinationally so the caller can latch it on the Nth edge.
// Ties keep the earlier index because the running maximum is replaced only on
// a strictly greater value.
// ---------------------------------------------------------------------------
module argmax_seq
    import nn_ctrl_pkg::*;
#(
    parameter int N     = NN_O_NODES,
    parameter int IDX_W = NN_IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go_i,
    input  logic [N*8-1:0]   values_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    logic                    running_q;
    logic [IDX_W-1:0]        ptr_q;
    logic [IDX_W-1:0]        best_idx_q;
    logic signed [7:0]       best_q;
    logic signed [7:0]       cur;
    logic                    take;
    logic [IDX_W-1:0]        ptr_d;

    always_comb begin
        cur     = $signed(values_i[ptr_q*8 +: 8]);
        take    = (cur > best_q);
        ptr_d   = ptr_q + IDX_W'(1);
        idx_o   = take ? ptr_q : best_idx_q;
        valid_o = running_q && (ptr_q == LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            running_q  <= 1'b0;
            ptr_q      <= '0;
            best_idx_q <= '0;
            best_q     <= '0;
        end else if (go_i) begin
            running_q  <= 1'b1;
            ptr_q      <= IDX_W'(1);
            best_idx_q <= '0;
            best_q     <= $signed(values_i[7:0]);
        end else if (running_q) begin
            if (take) begin
                best_q     <= cur;
                best_idx_q <= ptr_q;
            end
            if (ptr_q == LAST) begin
                running_q <= 1'b0;
            end else begin
                ptr_q <= ptr_d;
            end
        end
    end

endmodule

// File: rtl/neuron_layer_sequencer.sv
// ---------------------------------------------------------------------------
// neuron_layer_sequencer
// Drives the shared neuron array through hidden-upper, hidden-lower and
// output phases, latches lane outputs, then runs a serial argmax.
// Ports:
//   clk, rst               : clock, asynchronous active-high reset
//   start                  : pass request, honoured only in IDLE/DONE/ERROR
//   ctrl_data_w_b_neuron   : phase select (00 upper, 01 lower, 10 out, 11 idle)
//   start_signal           : one-cycle start pulse to all lanes
//   lane_out, lane_ready   : lane results and per-lane ready
//   out_regs               : latched hidden activations (20 bytes)
//   result                 : latched output-layer values (10 bytes)
//   class_idx              : argmax of result
//   busy, done, error      : status flags
//   dbg_state              : current controller state
// Valid/ready: the array's result is accepted only in a *_WAIT state on an
// edge where every lane_ready bit is high; ready seen during *_GO is stale
// from the previous phase and is ignored. All outputs are registered.
// ---------------------------------------------------------------------------
module neuron_layer_sequencer
    import nn_ctrl_pkg::*;
#(
    parameter int LANES         = NN_LANES,
    parameter int H_NODE_NUMBER = NN_H_NODES,
    parameter int O_NODE_NUMBER = NN_O_NODES,
    parameter int TIMEOUT       = NN_TIMEOUT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [1:0]                 ctrl_data_w_b_neuron,
    output logic                       start_signal,
    input  logic [LANES*8-1:0]         lane_out,
    input  logic [LANES-1:0]           lane_ready,
    output logic [H_NODE_NUMBER*8-1:0] out_regs,
    output logic [O_NODE_NUMBER*8-1:0] result,
    output logic [NN_IDX_W-1:0]        class_idx,
    output logic                       busy,
    output logic                       done,
    output logic                       error,
    output logic [3:0]                 dbg_state
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    nn_state_e                  state_q;
    logic [1:0]                 ctrl_q;
    logic                       start_signal_q;
    logic                       busy_q;
    logic                       done_q;
    logic                       error_q;
    logic                       am_go_q;
    logic [CNT_W-1:0]           wait_cnt_q;
    logic [CNT_W-1:0]           wait_cnt_d;
    logic [H_NODE_NUMBER*8-1:0] out_regs_q;
    logic [O_NODE_NUMBER*8-1:0] result_q;
    logic [NN_IDX_W-1:0]        class_idx_q;

    logic                       all_ready;
    logic                       timed_out;
    logic [NN_IDX_W-1:0]        am_idx;
    logic                       am_valid;

    always_comb begin
        all_ready  = &lane_ready;
        wait_cnt_d = wait_cnt_q + CNT_W'(1);
        // The edge that would bring the counter to TIMEOUT is the error edge.
        timed_out  = (wait_cnt_q == CNT_LAST);
    end

    argmax_seq #(
        .N     (O_NODE_NUMBER),
        .IDX_W (NN_IDX_W)
    ) u_argmax (
        .clk      (clk),
        .rst      (rst),
        .go_i     (am_go_q),
        .values_i (result_q),
        .idx_o    (am_idx),
        .valid_o  (am_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= S_IDLE;
            ctrl_q         <= CTRL_IDLE;
            start_signal_q <= 1'b0;
            busy_q         <= 1'b0;
            done_q         <= 1'b0;
            error_q        <= 1'b0;
            am_go_q        <= 1'b0;
            wait_cnt_q     <= '0;
            out_regs_q     <= '0;
            result_q       <= '0;
            class_idx_q    <= '0;
        end else begin
            start_signal_q <= 1'b0;
            am_go_q        <= 1'b0;
            unique case (state_q)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        state_q        <= S_H0_GO;
                        ctrl_q         <= CTRL_H_UPPER;
                        start_signal_q <= 1'b1;
                        busy_q         <= 1'b1;
                        done_q         <= 1'b0;
                        error_q        <= 1'b0;
                    end
                end
                S_H0_GO: begin
                    state_q    <= S_H0_WAIT;
                    wait_cnt_q <= '0;
                end
                S_H1_GO: begin
                    state_q    <= S_H1_WAIT;
                    wait_cnt_q <= '0;
                end
                S_O_GO: begin
                    state_q    <= S_O_WAIT;
                    wait_cnt_q <= '0;
                end
                S_H0_WAIT, S_H1_WAIT, S_O_WAIT: begin
                    // Ready on the timeout edge still completes the phase.
                    if (all_ready) begin
                        if (state_q == S_H0_WAIT) begin
                            out_regs_q[0 +: LANES*8] <= lane_out;
                            state_q                  <= S_H1_GO;
                            ctrl_q                   <= CTRL_H_LOWER;
                            start_signal_q           <= 1'b1;
                        end else if (state_q == S_H1_WAIT) begin
                            out_regs_q[LANES*8 +: LANES*8] <= lane_out;
                            state_q                        <= S_O_GO;
                            ctrl_q                         <= CTRL_OUT;
                            start_signal_q                 <= 1'b1;
                        end else begin
                            result_q <= lane_out;
                            state_q  <= S_ARGMAX;
                            ctrl_q   <= CTRL_IDLE;
                            am_go_q  <= 1'b1;
                        end
                    end else if (timed_out) begin
                        state_q <= S_ERROR;
                        ctrl_q  <= CTRL_IDLE;
                        busy_q  <= 1'b0;
                        error_q <= 1'b1;
                    end else begin
                        wait_cnt_q <= wait_cnt_d;
                    end
                end
                S_ARGMAX: begin
                    if (am_valid) begin
                        class_idx_q <= am_idx;
                        state_q     <= S_DONE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ctrl_q  <= CTRL_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ctrl_data_w_b_neuron = ctrl_q;
    assign start_signal         = start_signal_q;
    assign out_regs             = out_regs_q;
    assign result               = result_q;
    assign class_idx            = class_idx_q;
    assign busy                 = busy_q;
    assign done                 = done_q;
    assign error                = error_q;
    assign dbg_state            = state_q;

endmodule

// File: tb/tb_neuron_layer_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neuron_layer_sequencer
// Directed + randomized bench for neuron_layer_sequencer with TIMEOUT=16.
// A lane responder emulates the neuron array: it drops ready on the edge that
// samples start_signal, then presents the phase's values after a per-phase
// delay. Expected banks, argmax and latencies come from plain arithmetic.
// ---------------------------------------------------------------------------
module tb_neuron_layer_sequencer;

    localparam int TO = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [1:0]   ctrl;
    logic         start_signal;
    logic [79:0]  lane_out;
    logic [9:0]   lane_ready;
    logic [159:0] out_regs;
    logic [79:0]  result;
    logic [3:0]   class_idx;
    logic         busy;
    logic         done;
    logic         error;
    logic [3:0]   dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [7:0] hv[20];
    logic [7:0] ov[10];
    int         dly[3];
    logic [9:0] stuck[3];

    always #5 clk = ~clk;

    neuron_layer_sequencer #(
        .LANES         (10),
        .H_NODE_NUMBER (20),
        .O_NODE_NUMBER (10),
        .TIMEOUT       (TO)
    ) dut (
        .clk                  (clk),
        .rst                  (rst),
        .start                (start),
        .ctrl_data_w_b_neuron (ctrl),
        .start_signal         (start_signal),
        .lane_out             (lane_out),
        .lane_ready           (lane_ready),
        .out_regs             (out_regs),
        .result               (result),
        .class_idx            (class_idx),
        .busy                 (busy),
        .done                 (done),
        .error                (error),
        .dbg_state            (dbg_state)
    );

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [159:0] pack_hidden();
        logic [159:0] v;
        for (int i = 0; i < 20; i++) v[i*8 +: 8] = hv[i];
        return v;
    endfunction

    function automatic logic [79:0] pack_out();
        logic [79:0] v;
        for (int i = 0; i < 10; i++) v[i*8 +: 8] = ov[i];
        return v;
    endfunction

    function automatic logic [79:0] phase_vals(input int ph);
        logic [79:0] v;
        for (int i = 0; i < 10; i++) begin
            if (ph == 0)      v[i*8 +: 8] = hv[i];
            else if (ph == 1) v[i*8 +: 8] = hv[i+10];
            else              v[i*8 +: 8] = ov[i];
        end
        return v;
    endfunction

    // First index holding the largest signed value.
    function automatic logic [3:0] ref_argmax();
        int best;
        int bi;
        int v;
        best = $signed(ov[0]);
        bi   = 0;
        for (int i = 1; i < 10; i++) begin
            v = $signed(ov[i]);
            if (v > best) begin
                best = v;
                bi   = i;
            end
        end
        return 4'(bi);
    endfunction

    // Lane responder.
    initial begin
        logic       ssp;
        logic [1:0] cp;
        int         cnt;
        int         ph;
        bit         act;
        lane_out   = '0;
        lane_ready = '0;
        cnt = 0;
        ph  = 0;
        act = 0;
        forever begin
            @(negedge clk);
            ssp = start_signal;
            cp  = ctrl;
            @(posedge clk);
            #1;
            if (ssp === 1'b1 && cp !== 2'b11) begin
                ph = int'(cp);
                if (dly[ph] == 0) begin
                    lane_out   = phase_vals(ph);
                    lane_ready = ~stuck[ph];
                    act        = 0;
                end else begin
                    lane_ready = '0;
                    cnt        = dly[ph];
                    act        = 1;
                end
            end else if (act) begin
                cnt--;
                if (cnt == 0) begin
                    lane_out   = phase_vals(ph);
                    lane_ready = ~stuck[ph];
                    act        = 0;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_reset(input string p);
        check({p, "_ctrl"},      160'(ctrl),         160'(2'b11));
        check({p, "_ss"},        160'(start_signal), 160'(0));
        check({p, "_out_regs"},  out_regs,           160'(0));
        check({p, "_result"},    160'(result),       160'(0));
        check({p, "_class_idx"}, 160'(class_idx),    160'(0));
        check({p, "_busy"},      160'(busy),         160'(0));
        check({p, "_done"},      160'(done),         160'(0));
        check({p, "_error"},     160'(error),        160'(0));
    endtask

    task automatic run_pass(input string name, input bit inject);
        logic [159:0] exp_regs;
        logic [79:0]  exp_res;
        logic [79:0]  res_snap;
        logic [3:0]   exp_idx;
        logic [1:0]   last_c;
        logic [7:0]   seq;
        int           k, lat, exp_lat, ss_cnt, nseq, extra_ss;
        bit           fin, injected;
        exp_regs = pack_hidden();
        exp_res  = pack_out();
        exp_idx  = ref_argmax();
        exp_lat  = (dly[0] + 2) + (dly[1] + 2) + (dly[2] + 2) + 10;
        res_snap = result;
        start = 1'b1;
        tick();
        start = 1'b0;
        k = cyc;
        check({name, "_go_ss"},    160'(start_signal), 160'(1));
        check({name, "_go_busy"},  160'(busy),         160'(1));
        check({name, "_go_ctrl"},  160'(ctrl),         160'(2'b00));
        check({name, "_go_flags"}, 160'({done, error}), 160'(0));
        ss_cnt   = 1;
        last_c   = ctrl;
        seq      = {6'b0, ctrl};
        nseq     = 1;
        fin      = 0;
        injected = 0;
        lat      = -1;
        for (int n = 0; n < 300 && !fin; n++) begin
            if (inject && !injected && ctrl == 2'b10 && !start_signal) begin
                start    = 1'b1;
                injected = 1;
            end
            tick();
            start = 1'b0;
            if (start_signal) ss_cnt++;
            if (ctrl !== last_c) begin
                seq    = {seq[5:0], ctrl};
                nseq++;
                last_c = ctrl;
            end
            // Output phase: result must not move before the WAIT latch edge.
            if (ctrl == 2'b10) check({name, "_o_hold"}, 160'(result), 160'(res_snap));
            if (done) begin
                fin = 1;
                lat = cyc - k;
            end
        end
        check({name, "_done_latency"}, 160'(lat),       160'(exp_lat));
        check({name, "_out_regs"},     out_regs,        exp_regs);
        check({name, "_result"},       160'(result),    160'(exp_res));
        check({name, "_class_idx"},    160'(class_idx), 160'(exp_idx));
        check({name, "_end_busy"},     160'(busy),      160'(0));
        check({name, "_end_error"},    160'(error),     160'(0));
        check({name, "_end_ctrl"},     160'(ctrl),      160'(2'b11));
        check({name, "_ss_count"},     160'(ss_cnt),    160'(3));
        check({name, "_ctrl_changes"}, 160'(nseq),      160'(4));
        check({name, "_ctrl_seq"},     160'(seq),       160'(8'b00_01_10_11));
        extra_ss = 0;
        repeat (3) begin
            tick();
            if (start_signal) extra_ss++;
            check({name, "_done_hold"}, 160'(done), 160'(1));
        end
        check({name, "_no_extra_pass"}, 160'(extra_ss), 160'(0));
    endtask

    task automatic rand_vals();
        for (int i = 0; i < 20; i++) hv[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 10; i++) ov[i] = 8'($urandom_range(0, 255));
    endtask

    initial begin
        logic [159:0] snap;
        logic [159:0] exp_regs;
        logic [159:0] newh;
        int           k, lat, ss_cnt, r;
        bit           fin;

        for (int p = 0; p < 3; p++) begin
            dly[p]   = 4;
            stuck[p] = '0;
        end
        for (int i = 0; i < 20; i++) hv[i] = '0;
        for (int i = 0; i < 10; i++) ov[i] = '0;

        rst   = 1'b1;
        start = 1'b0;
        repeat (2) tick();
        check_reset("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Nominal: hidden 1..20, lane 3 strictly largest.
        for (int i = 0; i < 20; i++) hv[i] = 8'(i + 1);
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, 132);
            ov[i] = (r <= 4) ? 8'(r) : 8'(r + 123);
        end
        ov[3] = 8'h05;
        run_pass("nominal", 0);

        // Signed compare.
        rand_vals();
        ov[0] = 8'h80;
        ov[1] = 8'h7F;
        ov[2] = 8'hFF;
        for (int i = 3; i < 10; i++) ov[i] = 8'($urandom_range(0, 126));
        run_pass("signed", 0);

        // Ties go to the lowest index.
        rand_vals();
        for (int i = 0; i < 10; i++) ov[i] = 8'h10;
        run_pass("ties", 0);

        // Random values and lane delays.
        for (int t = 0; t < 3; t++) begin
            rand_vals();
            for (int p = 0; p < 3; p++) dly[p] = $urandom_range(0, 6);
            run_pass($sformatf("rand%0d", t), 0);
        end

        // Start pulsed while busy in O_WAIT.
        rand_vals();
        for (int p = 0; p < 3; p++) dly[p] = 3;
        run_pass("busy_start", 1);

        // Timeout: lane 7 never ready in the hidden-lower phase.
        snap = out_regs;
        rand_vals();
        for (int p = 0; p < 3; p++) dly[p] = 4;
        stuck[1] = 10'b00_1000_0000;
        newh     = pack_hidden();
        exp_regs = {snap[159:80], newh[79:0]};
        start = 1'b1;
        tick();
        start = 1'b0;
        k      = cyc;
        ss_cnt = 1;
        fin    = 0;
        lat    = -1;
        for (int n = 0; n < 300 && !fin; n++) begin
            tick();
            if (start_signal) ss_cnt++;
            if (error) begin
                fin = 1;
                lat = cyc - k;
            end
        end
        // H1_WAIT is entered at k + (1+W0) + 1; error follows TO cycles later.
        check("timeout_latency",  160'(lat),      160'((dly[0] + 2) + 1 + TO));
        check("timeout_ctrl",     160'(ctrl),     160'(2'b11));
        check("timeout_busy",     160'(busy),     160'(0));
        check("timeout_done",     160'(done),     160'(0));
        check("timeout_ss_count", 160'(ss_cnt),   160'(2));
        check("timeout_out_regs", out_regs,       exp_regs);
        repeat (2) tick();
        check("timeout_error_hold", 160'(error), 160'(1));

        // Restart from ERROR.
        stuck[1] = '0;
        rand_vals();
        run_pass("restart", 0);

        // Reset in the middle of H1_WAIT.
        rand_vals();
        for (int p = 0; p < 3; p++) dly[p] = 3;
        start = 1'b1;
        tick();
        start = 1'b0;
        fin = 0;
        for (int n = 0; n < 60 && !fin; n++) begin
            tick();
            if (ctrl == 2'b01 && !start_signal) fin = 1;
        end
        check("midrst_reached_h1_wait", 160'(fin), 160'(1));
        #3;
        rst = 1'b1;
        #1;
        check_reset("midrst_async");
        tick();
        rst = 1'b0;
        repeat (8) tick();
        check("midrst_idle_busy", 160'(busy), 160'(0));
        rand_vals();
        for (int p = 0; p < 3; p++) dly[p] = $urandom_range(0, 6);
        run_pass("post_reset", 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
